// File: rtl/bus_arbiter2.sv
// ---------------------------------------------------------------------------
// bus_arbiter2
// Two-master, one-slave bus arbiter (master 0 = CPU, master 1 = DMA) with
// alternating priority on contention and a per-transfer ack timeout.
//
// Ports
//   clk_i, rst_i        : clock (rising edge), async active-high reset
//   m_cyc[1:0]          : per-master cycle request
//   m_we[1:0]           : per-master write enable
//   m_adr[63:0]         : per-master address, master i in [32i+31:32i]
//   m_dat_o[63:0]       : per-master write data, master i in [32i+31:32i]
//   m_sel[7:0]          : per-master byte enables, master i in [4i+3:4i]
//   m_ack[1:0]          : per-master acknowledge (owner only)
//   m_err[1:0]          : per-master one-cycle timeout error pulse
//   m_dat_i[31:0]       : slave read data broadcast to both masters
//   s_cyc/s_we/s_adr/s_dat_o/s_sel : shared slave-side bus, driven by owner
//   s_ack, s_dat_i      : slave acknowledge and read data
//   grant[1:0]          : registered one-hot-or-zero current owner
// ---------------------------------------------------------------------------
module bus_arbiter2 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  m_cyc,
  input  logic [1:0]  m_we,
  input  logic [63:0] m_adr,
  input  logic [63:0] m_dat_o,
  input  logic [7:0]  m_sel,
  output logic [1:0]  m_ack,
  output logic [1:0]  m_err,
  output logic [31:0] m_dat_i,
  output logic        s_cyc,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel,
  input  logic        s_ack,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant
);

  localparam int unsigned CW = 16;

  // State encoding doubles as the grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  state_e          state_q;
  logic            last_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [1:0]      err_q;
  logic [1:0]      err_d;

  assign grant = 2'(state_q);

  // Arbitration FSM; last_q records the most recent owner for alternation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (m_cyc == 2'b11) begin
            if (last_q) begin
              state_q <= OWN0;
              last_q  <= 1'b0;
            end else begin
              state_q <= OWN1;
              last_q  <= 1'b1;
            end
          end else if (m_cyc[0]) begin
            state_q <= OWN0;
            last_q  <= 1'b0;
          end else if (m_cyc[1]) begin
            state_q <= OWN1;
            last_q  <= 1'b1;
          end
        end
        OWN0:    if (!m_cyc[0]) state_q <= IDLE;
        OWN1:    if (!m_cyc[1]) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ack wait counter; an ack in the terminal cycle wins over the timeout.
  always_comb begin
    cnt_d = cnt_q;
    err_d = 2'b00;
    if (state_q == IDLE || s_ack) begin
      cnt_d = '0;
    end else if (s_cyc) begin
      if (cnt_q == CW'(TIMEOUT - 1)) begin
        cnt_d = '0;
        err_d = grant;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign m_err = err_q;

  // Slave-side mux from the current owner; everything idles low without one.
  always_comb begin
    s_cyc   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    s_sel   = '0;
    if (state_q == OWN0) begin
      s_cyc   = m_cyc[0];
      s_we    = m_we[0];
      s_adr   = m_adr[31:0];
      s_dat_o = m_dat_o[31:0];
      s_sel   = m_sel[3:0];
    end else if (state_q == OWN1) begin
      s_cyc   = m_cyc[1];
      s_we    = m_we[1];
      s_adr   = m_adr[63:32];
      s_dat_o = m_dat_o[63:32];
      s_sel   = m_sel[7:4];
    end
  end

  assign m_ack   = {2{s_ack}} & grant & m_cyc;
  assign m_dat_i = s_dat_i;

endmodule

// File: tb/tb_bus_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter2
// Directed self-checking bench for bus_arbiter2 (TIMEOUT = 4). Inputs are
// driven just after each falling edge and outputs sampled 1 time unit later,
// so every check lands mid-cycle, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_bus_arbiter2;

  logic        clk_i;
  logic        rst_i;
  logic [1:0]  m_cyc;
  logic [1:0]  m_we;
  logic [63:0] m_adr;
  logic [63:0] m_dat_o;
  logic [7:0]  m_sel;
  logic [1:0]  m_ack;
  logic [1:0]  m_err;
  logic [31:0] m_dat_i;
  logic        s_cyc;
  logic        s_we;
  logic [31:0] s_adr;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel;
  logic        s_ack;
  logic [31:0] s_dat_i;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter2 #(.TIMEOUT(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .m_cyc   (m_cyc),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dat_o (m_dat_o),
    .m_sel   (m_sel),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_dat_i (m_dat_i),
    .s_cyc   (s_cyc),
    .s_we    (s_we),
    .s_adr   (s_adr),
    .s_dat_o (s_dat_o),
    .s_sel   (s_sel),
    .s_ack   (s_ack),
    .s_dat_i (s_dat_i),
    .grant   (grant)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    // Requests and ack asserted while in reset must not produce a grant or ack.
    @(negedge clk_i); #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b exp 00", grant); end
    n_checks++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_s_cyc: got %b exp 0", s_cyc); end
    n_checks++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL reset_m_ack: got %b exp 00", m_ack); end
    n_checks++; if (m_err !== 2'b00) begin n_fail++; $display("FAIL reset_m_err: got %b exp 00", m_err); end
    rst_i = 1'b0; m_cyc = 2'b00; s_ack = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk_i);
    m_cyc = 2'b01; m_we = 2'b01; m_adr[31:0] = 32'h0000_0100;
    m_dat_o[31:0] = 32'hDEAD_BEEF; m_sel[3:0] = 4'hF; #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_latency_grant: got %b exp 00", grant); end
    n_checks++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL single_latency_s_cyc: got %b exp 0", s_cyc); end
    @(negedge clk_i); #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b exp 01", grant); end
    n_checks++; if (s_cyc !== 1'b1) begin n_fail++; $display("FAIL single_s_cyc: got %b exp 1", s_cyc); end
    n_checks++; if (s_adr !== 32'h0000_0100) begin n_fail++; $display("FAIL single_s_adr: got %h exp 00000100", s_adr); end
    n_checks++; if (s_dat_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_s_dat_o: got %h exp deadbeef", s_dat_o); end
    n_checks++; if ({s_we, s_sel} !== 5'h1F) begin n_fail++; $display("FAIL single_we_sel: got %b exp 11111", {s_we, s_sel}); end
    n_checks++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL single_no_early_ack: got %b exp 00", m_ack); end
    @(negedge clk_i); #1;
    n_checks++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL single_wait_ack: got %b exp 00", m_ack); end
    @(negedge clk_i); s_ack = 1'b1; s_dat_i = 32'hCAFE_F00D; #1;
    n_checks++; if (m_ack !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b exp 01", m_ack); end
    n_checks++; if (m_dat_i !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL single_m_dat_i: got %h exp cafef00d", m_dat_i); end
    n_checks++; if (m_err !== 2'b00) begin n_fail++; $display("FAIL single_no_err: got %b exp 00", m_err); end
    @(negedge clk_i); s_ack = 1'b0; m_cyc = 2'b00; #1;
    n_checks++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_one_pulse: got %b exp 00", m_ack); end
    n_checks++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL single_s_cyc_drop: got %b exp 0", s_cyc); end
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant_hold: got %b exp 01", grant); end
    @(negedge clk_i); #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_idle: got %b exp 00", grant); end
    n_checks++; if (s_adr !== 32'h0) begin n_fail++; $display("FAIL single_idle_s_adr: got %h exp 00000000", s_adr); end
  endtask

  task automatic test_contention();
    // Fresh reset so last = 1 and master 0 wins the first contention.
    @(negedge clk_i); rst_i = 1'b1; #1; rst_i = 1'b0;
    m_cyc = 2'b11; m_we = 2'b00; m_adr = {32'h0000_0200, 32'h0000_0100}; #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL cont_req_cycle: got %b exp 00", grant); end
    @(negedge clk_i); s_ack = 1'b1; #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL cont_first_grant: got %b exp 01", grant); end
    n_checks++; if (s_adr !== 32'h0000_0100) begin n_fail++; $display("FAIL cont_first_adr: got %h exp 00000100", s_adr); end
    n_checks++; if (m_ack !== 2'b01) begin n_fail++; $display("FAIL cont_first_ack: got %b exp 01", m_ack); end
    @(negedge clk_i); s_ack = 1'b0; m_cyc = 2'b10; #1;
    n_checks++; if (grant !== 2'b01 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL cont_release0: got grant %b s_cyc %b exp 01 0", grant, s_cyc); end
    @(negedge clk_i); m_cyc = 2'b11; #1;
    n_checks++; if (grant !== 2'b00 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL cont_idle_gap1: got grant %b s_cyc %b exp 00 0", grant, s_cyc); end
    @(negedge clk_i); s_ack = 1'b1; #1;
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL cont_second_grant: got %b exp 10", grant); end
    n_checks++; if (s_adr !== 32'h0000_0200) begin n_fail++; $display("FAIL cont_second_adr: got %h exp 00000200", s_adr); end
    n_checks++; if (m_ack !== 2'b10) begin n_fail++; $display("FAIL cont_second_ack: got %b exp 10", m_ack); end
    @(negedge clk_i); s_ack = 1'b0; m_cyc = 2'b01; #1;
    n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL cont_release1: got %b exp 10", grant); end
    @(negedge clk_i); m_cyc = 2'b11; #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL cont_idle_gap2: got %b exp 00", grant); end
    @(negedge clk_i); #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL cont_third_grant: got %b exp 01", grant); end
    @(negedge clk_i); m_cyc = 2'b00;
  endtask

  task automatic test_no_preempt();
    @(negedge clk_i); m_cyc = 2'b10; #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL nopre_req_cycle: got %b exp 00", grant); end
    @(negedge clk_i); m_cyc = 2'b11; #1;
    n_checks++; if (grant !== 2'b10 || s_adr !== 32'h0000_0200) begin n_fail++; $display("FAIL nopre_owner1: got grant %b adr %h exp 10 00000200", grant, s_adr); end
    @(negedge clk_i); s_ack = 1'b1; #1;
    n_checks++; if (m_ack !== 2'b10) begin n_fail++; $display("FAIL nopre_ack_owner_only: got %b exp 10", m_ack); end
    @(negedge clk_i); s_ack = 1'b0; #1;
    n_checks++; if (grant !== 2'b10 || m_ack !== 2'b00) begin n_fail++; $display("FAIL nopre_hold: got grant %b ack %b exp 10 00", grant, m_ack); end
    @(negedge clk_i); m_cyc = 2'b01; #1;
    n_checks++; if (grant !== 2'b10 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL nopre_release: got grant %b s_cyc %b exp 10 0", grant, s_cyc); end
    @(negedge clk_i); #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL nopre_idle: got %b exp 00", grant); end
    @(negedge clk_i); #1;
    n_checks++; if (grant !== 2'b01 || s_adr !== 32'h0000_0100) begin n_fail++; $display("FAIL nopre_m0_granted: got grant %b adr %h exp 01 00000100", grant, s_adr); end
    @(negedge clk_i); m_cyc = 2'b00;
  endtask

  task automatic test_ack_in_idle();
    @(negedge clk_i); s_ack = 1'b1; s_dat_i = 32'h1234_5678; #1;
    n_checks++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL idle_ack_ignored: got %b exp 00", m_ack); end
    n_checks++; if (m_dat_i !== 32'h1234_5678) begin n_fail++; $display("FAIL idle_m_dat_i: got %h exp 12345678", m_dat_i); end
    @(negedge clk_i); m_cyc = 2'b01; #1;
    n_checks++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL idle_ack_req_cycle: got %b exp 00", m_ack); end
    @(negedge clk_i); s_ack = 1'b0; m_cyc = 2'b00;
  endtask

  task automatic test_timeout();
    // Master 1 waits forever: err pulses 4 and 8 cycles after s_cyc rises.
    @(negedge clk_i); m_cyc = 2'b10; s_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i); #1;
      n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL tmo_grant k=%0d: got %b exp 10", k, grant); end
      n_checks++; if (m_err !== ((k == 4 || k == 8) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL tmo_err k=%0d: got %b exp %b", k, m_err, (k == 4 || k == 8) ? 2'b10 : 2'b00); end
    end
    @(negedge clk_i); m_cyc = 2'b00; #1;
    n_checks++; if (m_err !== 2'b00 || s_cyc !== 1'b0) begin n_fail++; $display("FAIL tmo_drop: got err %b s_cyc %b exp 00 0", m_err, s_cyc); end
    @(negedge clk_i); #1;
    n_checks++; if (grant !== 2'b00 || m_err !== 2'b00) begin n_fail++; $display("FAIL tmo_idle: got grant %b err %b exp 00 00", grant, m_err); end
  endtask

  task automatic test_ack_timeout_tie();
    // Ack lands on the terminal count cycle (k=3); counter restarts from there.
    @(negedge clk_i); m_cyc = 2'b01;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_i); s_ack = (k == 3); #1;
      n_checks++; if (m_ack !== ((k == 3) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL tie_ack k=%0d: got %b exp %b", k, m_ack, (k == 3) ? 2'b01 : 2'b00); end
      n_checks++; if (m_err !== ((k == 8) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL tie_err k=%0d: got %b exp %b", k, m_err, (k == 8) ? 2'b01 : 2'b00); end
    end
    @(negedge clk_i); s_ack = 1'b0; m_cyc = 2'b00; #1;
    n_checks++; if (m_err !== 2'b00) begin n_fail++; $display("FAIL tie_err_single: got %b exp 00", m_err); end
  endtask

  task automatic test_reset_mid_transfer();
    @(negedge clk_i); m_cyc = 2'b01;
    @(negedge clk_i); s_ack = 1'b1; #1;
    n_checks++; if (s_cyc !== 1'b1 || m_ack !== 2'b01) begin n_fail++; $display("FAIL rstmid_pre: got s_cyc %b ack %b exp 1 01", s_cyc, m_ack); end
    rst_i = 1'b1; #1;
    n_checks++; if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL rstmid_s_cyc: got %b exp 0", s_cyc); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rstmid_grant: got %b exp 00", grant); end
    n_checks++; if (m_ack !== 2'b00) begin n_fail++; $display("FAIL rstmid_m_ack: got %b exp 00", m_ack); end
    @(negedge clk_i); rst_i = 1'b0; s_ack = 1'b0; m_cyc = 2'b11; #1;
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL rstmid_held: got %b exp 00", grant); end
    @(negedge clk_i); #1;
    n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rstmid_m0_wins: got %b exp 01", grant); end
    @(negedge clk_i); m_cyc = 2'b00;
  endtask

  initial begin
    rst_i = 1'b1; m_cyc = 2'b11; m_we = 2'b00; m_adr = '0; m_dat_o = '0;
    m_sel = '0; s_ack = 1'b1; s_dat_i = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_no_preempt();
    test_ack_in_idle();
    test_timeout();
    test_ack_timeout_tie();
    test_reset_mid_transfer();
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 255, meaning max cycles a granted bus cycle may wait for s_ack before error (range 2..65535).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port m_cyc  input  2  per-master bus request/cycle, bit i = master i (0 = CPU, 1 = DMA).
REQ-005 SHALL have port m_we  input  2  per-master write enable.
REQ-006 SHALL have port m_adr  input  64  per-master address, bits [32i+31:32i].
REQ-007 SHALL have port m_dat_o  input  64  per-master write data, bits [32i+31:32i].
REQ-008 SHALL have port m_sel  input  8  per-master byte enables, bits [4i+3:4i].
REQ-009 SHALL have port m_ack  output  2  per-master acknowledge.
REQ-010 SHALL have port m_err  output  2  per-master timeout error pulse.
REQ-011 SHALL have port m_dat_i  output  32  read data broadcast to both masters.
REQ-012 SHALL have ports s_cyc, s_we (output 1), s_adr (output 32), s_dat_o (output 32), s_sel (output 4): shared slave-side bus.
REQ-013 SHALL have ports s_ack  input  1  and s_dat_i  input  32  from the slave.
REQ-014 SHALL have port grant  output  2  one-hot-or-zero current owner.

Function
REQ-015 SHALL implement FSM states IDLE, OWN0, OWN1; grant = 00/01/10 respectively, registered.
REQ-016 SHALL, in IDLE, move to OWNi on the next edge when only m_cyc[i] is high; stay IDLE when m_cyc = 00.
REQ-017 SHALL, in IDLE with m_cyc = 11, grant the master not equal to register last; last resets to 1 so master 0 wins first contention.
REQ-018 SHALL update last to i on entry to OWNi.
REQ-019 SHALL hold OWNi while m_cyc[i] is high regardless of the other master; no preemption.
REQ-020 SHALL return OWNi -> IDLE on the edge where m_cyc[i] is low; minimum one IDLE cycle between ownerships.
REQ-021 SHALL drive s_cyc = m_cyc[i] & grant[i] and s_we/s_adr/s_dat_o/s_sel from owner i combinationally; all zero in IDLE.
REQ-022 SHALL drive m_ack[i] = s_ack & grant[i] & m_cyc[i]; never to a non-owner; m_dat_i = s_dat_i unconditionally.
REQ-023 SHALL keep a 16-bit wait counter: cleared in IDLE or when s_ack is high, incremented each cycle s_cyc high and s_ack low.
REQ-024 SHALL, when the counter equals TIMEOUT-1 with s_ack low, pulse m_err[owner] for exactly one cycle and clear the counter; ownership retained until the owner drops m_cyc.
REQ-025 SHALL give s_ack priority over timeout in the same cycle (ack delivered, no err).
REQ-026 SHALL ignore s_ack while in IDLE (no m_ack asserted).
REQ-027 SHALL have arbitration latency of one cycle: request at edge n, s_cyc asserted after edge n+1.

Reset
REQ-028 SHALL, while rst_i is high, force state IDLE, grant 00, last 1, counter 0, m_err 00, hence s_cyc 0 and m_ack 00 immediately, including mid-transfer.
REQ-029 SHALL resume arbitration on the first rising clk_i edge after rst_i deasserts.

Verification
REQ-030 SHALL cover: m_cyc=01, m0 write adr 0x100 data 0xDEADBEEF sel 0xF, s_ack after 3 cycles -> grant 01 one cycle later, s_adr 0x100, m_ack[0] one pulse, IDLE after m_cyc drops.
REQ-031 SHALL cover: m_cyc=11 from reset, each master drops cyc after ack -> grant order 01, 10, 01, with one IDLE cycle between.
REQ-032 SHALL cover: m1 owns bus, m0 raises cyc mid-transfer -> grant stays 10, m_ack[0] never asserted, m0 granted after m1 releases.
REQ-033 SHALL cover: TIMEOUT=4, s_ack held low -> m_err[owner] pulses 4 cycles after s_cyc rises, repeats every 4 cycles until m_cyc drops.
REQ-034 SHALL cover: rst_i asserted during OWN0 with s_cyc high -> s_cyc, grant, m_ack zero without a clock edge; after release, m_cyc=11 grants master 0.
REQ-035 SHALL cover: s_ack and timeout coincide on cycle TIMEOUT-1 -> m_ack pulses, m_err stays 00.
